// File: rtl/spi_reg_bank.sv
// Double-buffered SPI register bank: write-only SPI frames land in shadow registers, i_commit publishes them.
// Latency: CSB pin rise -> shadow/pending/o_err (or live when DIRECT) in 4 cycles; i_commit -> o_regs in 1 cycle.
// Backpressure: none; SPI is free-running, frames arriving during CHECK/LOCKOUT are dropped, malformed frames pulse o_err.
//
// Ports:
//   i_clk, i_reset          system clock, asynchronous active-high reset
//   i_csb, i_sclk, i_mosi   SPI mode 0 pins, asynchronous to i_clk, MSB first
//   i_commit                copy every pending shadow to its live register (ignored when DIRECT=1)
//   o_regs                  live registers, register k at [k*DATA_W +: DATA_W]
//   o_pending               bit k set while shadow k holds an uncommitted write
//   o_err                   one-cycle pulse per rejected frame
//   o_busy                  synchronised chip select is low

module spi_reg_bank #(
    parameter int                         NREGS      = 8,
    parameter int                         ADDR_W     = 4,
    parameter int                         DATA_W     = 24,
    parameter logic [NREGS*DATA_W-1:0]    RESET_VALS = '0,
    parameter bit                         DIRECT     = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_csb,
    input  logic                          i_sclk,
    input  logic                          i_mosi,
    input  logic                          i_commit,
    output logic [NREGS*DATA_W-1:0]       o_regs,
    output logic [NREGS-1:0]              o_pending,
    output logic                          o_err,
    output logic                          o_busy
);

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W + 1)'(NREGS);

    typedef enum logic [1:0] {
        ST_LOCKOUT,
        ST_ARMED,
        ST_SHIFT,
        ST_CHECK
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one history stage for edge detection.
    // CSB idles high through reset so o_busy reads 0 while in reset.
    // ------------------------------------------------------------------
    logic csb_s1, csb_s2, csb_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            csb_s1  <= 1'b1;
            csb_s2  <= 1'b1;
            csb_d   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            csb_s1  <= i_csb;
            csb_s2  <= csb_s1;
            csb_d   <= csb_s2;
            sclk_s1 <= i_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= i_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    logic csb_rise;
    logic sclk_rise;

    assign csb_rise  = csb_s2 & ~csb_d;
    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign o_busy    = ~csb_s2;

    // ------------------------------------------------------------------
    // Frame receiver FSM, shift register and saturating bit counter.
    // ------------------------------------------------------------------
    state_t               state;
    logic [FRAME_W-1:0]   shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [1:0]           settle_cnt;

    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    logic                 frame_ok;
    logic                 wr_en;

    assign frame_addr = shift_reg[FRAME_W-1 -: ADDR_W];
    assign frame_data = shift_reg[DATA_W-1:0];
    // Exact length and an address that maps onto a real register.
    assign frame_ok   = (bit_cnt == CNT_FULL) && ({1'b0, frame_addr} < NREGS_W);
    assign wr_en      = (state == ST_CHECK) && frame_ok;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_LOCKOUT;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            o_err      <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                // The synchroniser still holds its reset value for the first
                // two cycles after reset; wait for it to refill from the pin
                // before trusting CSB high, otherwise a frame cut by reset
                // would be re-armed mid-frame and partly accepted.
                ST_LOCKOUT: begin
                    if (settle_cnt != 2'd2) begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end else if (csb_s2) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!csb_s2) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (csb_rise) begin
                        state <= ST_CHECK;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_W-2:0], mosi_s2};
                        // Saturate one past a full frame so long frames stay invalid.
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    state <= ST_ARMED;
                    o_err <= ~frame_ok;
                end
                default: begin
                    state <= ST_LOCKOUT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register storage. Commit reads the pre-cycle shadow/pending values,
    // so a write landing in the same cycle as a commit stays pending and
    // is published by the following commit.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] live_q   [NREGS];
    logic [DATA_W-1:0] shadow_q [NREGS];
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NREGS; k++) begin
            wr_hit[k] = wr_en && (frame_addr == ADDR_W'(k));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NREGS; k++) begin
                live_q[k]   <= RESET_VALS[k*DATA_W +: DATA_W];
                shadow_q[k] <= RESET_VALS[k*DATA_W +: DATA_W];
            end
            pend_q <= '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (DIRECT) begin
                    if (wr_hit[k]) begin
                        live_q[k] <= frame_data;
                    end
                end else begin
                    if (i_commit && pend_q[k]) begin
                        live_q[k] <= shadow_q[k];
                    end
                    if (wr_hit[k]) begin
                        shadow_q[k] <= frame_data;
                        pend_q[k]   <= 1'b1;
                    end else if (i_commit) begin
                        pend_q[k]   <= 1'b0;
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_out
            assign o_regs[g*DATA_W +: DATA_W] = live_q[g];
        end
    endgenerate

    assign o_pending = pend_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: a buffered instance (defaults) and a DIRECT=1 instance with non-zero reset image.
// Expected outcomes are queued when a frame ends and compared when the design is due to react.
// SPI pins are driven slowly (4 clocks per SCLK phase) on the falling clock edge; outputs are sampled there too.

module tb_spi_reg_bank;

    localparam logic [191:0] RV_D = {24'h777777, 24'h666666, 24'h555555, 24'h444444,
                                     24'h333333, 24'h222222, 24'h111111, 24'h0A0A0A};

    logic         clk = 1'b0;
    logic         rst;
    logic         csb_a, csb_b, sclk, mosi, commit;
    logic [191:0] a_regs, d_regs;
    logic [7:0]   a_pend, d_pend;
    logic         a_err, d_err, a_busy, d_busy;

    always #5 clk = ~clk;

    spi_reg_bank #(.NREGS(8), .ADDR_W(4), .DATA_W(24), .RESET_VALS('0), .DIRECT(1'b0)) dut (
        .i_clk(clk), .i_reset(rst), .i_csb(csb_a), .i_sclk(sclk), .i_mosi(mosi),
        .i_commit(commit), .o_regs(a_regs), .o_pending(a_pend), .o_err(a_err), .o_busy(a_busy)
    );

    spi_reg_bank #(.NREGS(8), .ADDR_W(4), .DATA_W(24), .RESET_VALS(RV_D), .DIRECT(1'b1)) dut_d (
        .i_clk(clk), .i_reset(rst), .i_csb(csb_b), .i_sclk(sclk), .i_mosi(mosi),
        .i_commit(commit), .o_regs(d_regs), .o_pending(d_pend), .o_err(d_err), .o_busy(d_busy)
    );

    typedef struct {
        logic         err;
        logic [7:0]   pend;
        logic [191:0] regs;
        logic [7:0]   prev_pend;
        logic [191:0] prev_regs;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [23:0] ma_live [8];
    logic [23:0] ma_shadow [8];
    logic [7:0]  ma_pend;
    logic [23:0] md_live [8];

    // ---------------- reference model ----------------
    function automatic logic [191:0] pack(input bit d);
        logic [191:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*24 +: 24] = d ? md_live[k] : ma_live[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            ma_live[k]   = 24'h0;
            ma_shadow[k] = 24'h0;
            md_live[k]   = RV_D[k*24 +: 24];
        end
        ma_pend = 8'h0;
    endtask

    task automatic model_commit();
        for (int k = 0; k < 8; k++) if (ma_pend[k]) ma_live[k] = ma_shadow[k];
        ma_pend = 8'h0;
    endtask

    task automatic model_frame(input bit d, input int nbits, input logic [3:0] addr,
                               input logic [23:0] data, input bit commit_now);
        exp_t e;
        bit   ok;
        e.prev_regs = pack(d);
        e.prev_pend = d ? 8'h0 : ma_pend;
        if (commit_now) model_commit();
        ok = (nbits == 28) && (addr < 4'd8);
        if (ok) begin
            if (d) md_live[addr[2:0]] = data;
            else begin
                ma_shadow[addr[2:0]]   = data;
                ma_pend[addr[2:0]]     = 1'b1;
            end
        end
        e.err  = !ok;
        e.pend = d ? 8'h0 : ma_pend;
        e.regs = pack(d);
        exp_q.push_back(e);
    endtask

    // ---------------- pin drivers ----------------
    function automatic logic [191:0] cur_regs(input bit d);
        return d ? d_regs : a_regs;
    endfunction
    function automatic logic [7:0] cur_pend(input bit d);
        return d ? d_pend : a_pend;
    endfunction
    function automatic logic cur_err(input bit d);
        return d ? d_err : a_err;
    endfunction

    task automatic begin_frame(input bit d);
        if (d) csb_b = 1'b0; else csb_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input int nbits, input logic [63:0] val);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame(input bit d);
        if (d) csb_b = 1'b1; else csb_a = 1'b1;
    endtask

    task automatic send_frame(input bit d, input int nbits, input logic [63:0] val);
        begin_frame(d);
        shift_bits(nbits, val);
        end_frame(d);
    endtask

    // Called right after CSB rises at the pin (on a falling clock edge).
    task automatic check_outcome(input bit d, input string name, input bit align);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no expected outcome queued", name);
            return;
        end
        repeat (3) @(negedge clk);
        if (align) commit = 1'b1;
        checks++;
        if (cur_err(d) !== 1'b0) begin errors++; $display("FAIL %s_early_err: got %0b want 0", name, cur_err(d)); end
        checks++;
        if (cur_regs(d) !== exp_q[0].prev_regs) begin errors++; $display("FAIL %s_early_regs: got %h want %h", name, cur_regs(d), exp_q[0].prev_regs); end
        checks++;
        if (cur_pend(d) !== exp_q[0].prev_pend) begin errors++; $display("FAIL %s_early_pend: got %h want %h", name, cur_pend(d), exp_q[0].prev_pend); end
        @(negedge clk);
        commit = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (cur_err(d) !== e.err) begin errors++; $display("FAIL %s_err: got %0b want %0b", name, cur_err(d), e.err); end
        checks++;
        if (cur_pend(d) !== e.pend) begin errors++; $display("FAIL %s_pend: got %h want %h", name, cur_pend(d), e.pend); end
        checks++;
        if (cur_regs(d) !== e.regs) begin errors++; $display("FAIL %s_regs: got %h want %h", name, cur_regs(d), e.regs); end
        @(negedge clk);
        checks++;
        if (cur_err(d) !== 1'b0) begin errors++; $display("FAIL %s_err_width: got %0b want 0", name, cur_err(d)); end
    endtask

    task automatic do_commit(input string name);
        commit = 1'b1;
        model_commit();
        @(negedge clk);
        commit = 1'b0;
        checks++;
        if (a_regs !== pack(0)) begin errors++; $display("FAIL %s_regs: got %h want %h", name, a_regs, pack(0)); end
        checks++;
        if (a_pend !== 8'h00) begin errors++; $display("FAIL %s_pend: got %h want 00", name, a_pend); end
        checks++;
        if (d_regs !== pack(1)) begin errors++; $display("FAIL %s_direct_regs: got %h want %h", name, d_regs, pack(1)); end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; csb_a = 1'b1; csb_b = 1'b1; sclk = 1'b0; mosi = 1'b0; commit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (a_regs !== 192'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", a_regs); end
        checks++; if (a_pend !== 8'h0)   begin errors++; $display("FAIL reset_pend: got %h want 0", a_pend); end
        checks++; if (a_err !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL reset_err_busy: got %0b%0b want 00", a_err, a_busy); end
        checks++; if (d_regs !== RV_D)   begin errors++; $display("FAIL reset_direct_regs: got %h want %h", d_regs, RV_D); end
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [23:0] r3;
        csb_a = 1'b0;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_latency1: got %0b want 0", a_busy); end
        @(negedge clk);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_latency2: got %0b want 1", a_busy); end
        repeat (2) @(negedge clk);
        shift_bits(28, {36'h0, 4'd3, 24'hABCDEF});
        end_frame(0);
        model_frame(0, 28, 4'd3, 24'hABCDEF, 1'b0);
        check_outcome(0, "basic", 1'b0);
        do_commit("basic_commit");
        r3 = a_regs[3*24 +: 24];
        checks++; if (r3 !== 24'hABCDEF) begin errors++; $display("FAIL basic_reg3: got %h want abcdef", r3); end
    endtask

    task automatic test_short_long();
        send_frame(0, 20, 64'h5_5555);
        model_frame(0, 20, 4'd0, 24'h0, 1'b0);
        check_outcome(0, "short20", 1'b0);
        send_frame(0, 29, {35'h0, 1'b0, 4'd2, 24'h123456});
        model_frame(0, 29, 4'd0, 24'h0, 1'b0);
        check_outcome(0, "long29", 1'b0);
    endtask

    task automatic test_range();
        send_frame(0, 28, {36'h0, 4'd9, 24'h123456});
        model_frame(0, 28, 4'd9, 24'h123456, 1'b0);
        check_outcome(0, "addr9", 1'b0);
        send_frame(0, 28, {36'h0, 4'd7, 24'h777000});
        model_frame(0, 28, 4'd7, 24'h777000, 1'b0);
        check_outcome(0, "addr7", 1'b0);
        do_commit("addr7_commit");
    endtask

    task automatic test_back_to_back();
        logic [23:0] r;
        send_frame(0, 28, {36'h0, 4'd1, 24'h111111});
        model_frame(0, 28, 4'd1, 24'h111111, 1'b0);
        check_outcome(0, "lww_first", 1'b0);
        send_frame(0, 28, {36'h0, 4'd1, 24'h222222});
        model_frame(0, 28, 4'd1, 24'h222222, 1'b0);
        check_outcome(0, "lww_second", 1'b0);
        do_commit("lww_commit");
        r = a_regs[1*24 +: 24];
        checks++; if (r !== 24'h222222) begin errors++; $display("FAIL lww_reg1: got %h want 222222", r); end
    endtask

    task automatic test_collision();
        logic [23:0] r;
        send_frame(0, 28, {36'h0, 4'd4, 24'h444444});
        model_frame(0, 28, 4'd4, 24'h444444, 1'b0);
        check_outcome(0, "pre_collide", 1'b0);
        send_frame(0, 28, {36'h0, 4'd2, 24'h0000FF});
        model_frame(0, 28, 4'd2, 24'h0000FF, 1'b1);
        check_outcome(0, "collide", 1'b1);
        r = a_regs[2*24 +: 24];
        checks++; if (r !== 24'h0) begin errors++; $display("FAIL collide_reg2_held: got %h want 000000", r); end
        do_commit("collide_commit");
        r = a_regs[2*24 +: 24];
        checks++; if (r !== 24'h0000FF) begin errors++; $display("FAIL collide_reg2_applied: got %h want 0000ff", r); end
    endtask

    task automatic test_direct();
        send_frame(1, 28, {36'h0, 4'd0, 24'hC0FFEE});
        model_frame(1, 28, 4'd0, 24'hC0FFEE, 1'b0);
        check_outcome(1, "direct", 1'b0);
        checks++; if (d_regs[23:0] !== 24'hC0FFEE) begin errors++; $display("FAIL direct_reg0: got %h want c0ffee", d_regs[23:0]); end
        do_commit("direct_commit");
        checks++; if (d_pend !== 8'h0) begin errors++; $display("FAIL direct_pend: got %h want 00", d_pend); end
    endtask

    task automatic test_reset_midframe();
        bit seen_err;
        begin_frame(0);
        shift_bits(12, {52'h0, 4'd6, 8'hAB});
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (a_regs !== 192'h0 || a_pend !== 8'h0) begin errors++; $display("FAIL midreset_state: regs %h pend %h want 0", a_regs, a_pend); end
        checks++; if (d_regs !== RV_D) begin errors++; $display("FAIL midreset_direct: got %h want %h", d_regs, RV_D); end
        checks++; if (a_busy !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL midreset_busy_err: got %0b%0b want 00", a_busy, a_err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        shift_bits(16, 64'hCDEF);
        end_frame(0);
        seen_err = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_err !== 1'b0) seen_err = 1'b1;
        end
        checks++; if (seen_err) begin errors++; $display("FAIL lockout_err: got 1 want 0"); end
        checks++; if (a_pend !== 8'h0 || a_regs !== 192'h0) begin errors++; $display("FAIL lockout_write: pend %h regs %h want 0", a_pend, a_regs); end
        send_frame(0, 28, {36'h0, 4'd5, 24'h5A5A5A});
        model_frame(0, 28, 4'd5, 24'h5A5A5A, 1'b0);
        check_outcome(0, "after_lockout", 1'b0);
        do_commit("after_lockout_commit");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_long();
        test_range();
        test_back_to_back();
        test_collision();
        test_direct();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
